// File: rtl/reference_model.sv
// rtl/reference_model.sv - 8237 CPU programming interface decode model with byte-pointer flip-flop
module reference_model #(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CS_N,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic [3:0]        A,
  input  logic              programCondition,
  output logic              loadBaseAddressReg,
  output logic              loadBaseWordCountReg,
  output logic              readCurrentAddressReg,
  output logic              readCurrentWordCountReg,
  output logic [NUM_CH-1:0] channelSel,
  output logic              loadCommandReg,
  output logic              loadRequestReg,
  output logic              loadSingleMask,
  output logic              loadModeReg,
  output logic              clearInternalFF,
  output logic              masterClear,
  output logic              clearMaskReg,
  output logic              loadAllMask,
  output logic              readStatusReg,
  output logic              readTemporaryReg,
  output logic              loadIoDataBufferFromStatus,
  output logic              upperByte
);

  logic valid;
  logic wr;
  logic rd;
  logic acc;
  logic accPrev;

  // Strobes are held off while reset is asserted as well as outside program mode.
  assign valid = RESET_N && !CS_N && programCondition && (IOR_N ^ IOW_N);
  assign wr    = valid && !IOW_N;
  assign rd    = valid && !IOR_N;

  always_comb begin
    loadBaseAddressReg      = 1'b0;
    loadBaseWordCountReg    = 1'b0;
    readCurrentAddressReg   = 1'b0;
    readCurrentWordCountReg = 1'b0;
    loadCommandReg          = 1'b0;
    loadRequestReg          = 1'b0;
    loadSingleMask          = 1'b0;
    loadModeReg             = 1'b0;
    clearInternalFF         = 1'b0;
    masterClear             = 1'b0;
    clearMaskReg            = 1'b0;
    loadAllMask             = 1'b0;
    readStatusReg           = 1'b0;
    readTemporaryReg        = 1'b0;
    if (wr) begin
      if (!A[3]) begin
        loadBaseAddressReg   = !A[0];
        loadBaseWordCountReg = A[0];
      end else begin
        case (A[2:0])
          3'd0:    loadCommandReg  = 1'b1;
          3'd1:    loadRequestReg  = 1'b1;
          3'd2:    loadSingleMask  = 1'b1;
          3'd3:    loadModeReg     = 1'b1;
          3'd4:    clearInternalFF = 1'b1;
          3'd5:    masterClear     = 1'b1;
          3'd6:    clearMaskReg    = 1'b1;
          default: loadAllMask     = 1'b1;
        endcase
      end
    end else if (rd) begin
      if (!A[3]) begin
        readCurrentAddressReg   = !A[0];
        readCurrentWordCountReg = A[0];
      end else if (A[2:0] == 3'd0) begin
        readStatusReg = 1'b1;
      end else if (A[2:0] == 3'd5) begin
        readTemporaryReg = 1'b1;
      end
    end
  end

  assign loadIoDataBufferFromStatus = readStatusReg;

  assign acc = loadBaseAddressReg | loadBaseWordCountReg |
               readCurrentAddressReg | readCurrentWordCountReg;

  assign channelSel = acc ? ({{(NUM_CH-1){1'b0}}, 1'b1} << A[2:1]) : '0;

  // Toggle on the falling edge of an access so a held strobe flips the pointer once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      upperByte <= 1'b0;
      accPrev   <= 1'b0;
    end else begin
      accPrev <= acc;
      if (clearInternalFF || masterClear) begin
        upperByte <= 1'b0;
      end else if (accPrev && !acc) begin
        upperByte <= !upperByte;
      end
    end
  end

endmodule

// File: tb/tb_reference_model.sv
// tb/tb_reference_model.sv - vector table and upperByte scoreboard bench for reference_model
module tb_reference_model;

  logic CLK = 1'b0;
  logic RESET_N;
  logic CS_N;
  logic IOR_N;
  logic IOW_N;
  logic [3:0] A;
  logic programCondition;
  logic loadBaseAddressReg, loadBaseWordCountReg, readCurrentAddressReg, readCurrentWordCountReg;
  logic [3:0] channelSel;
  logic loadCommandReg, loadRequestReg, loadSingleMask, loadModeReg;
  logic clearInternalFF, masterClear, clearMaskReg, loadAllMask;
  logic readStatusReg, readTemporaryReg, loadIoDataBufferFromStatus, upperByte;

  always #5 CLK = ~CLK;

  reference_model #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
    .programCondition(programCondition),
    .loadBaseAddressReg(loadBaseAddressReg), .loadBaseWordCountReg(loadBaseWordCountReg),
    .readCurrentAddressReg(readCurrentAddressReg), .readCurrentWordCountReg(readCurrentWordCountReg),
    .channelSel(channelSel), .loadCommandReg(loadCommandReg), .loadRequestReg(loadRequestReg),
    .loadSingleMask(loadSingleMask), .loadModeReg(loadModeReg), .clearInternalFF(clearInternalFF),
    .masterClear(masterClear), .clearMaskReg(clearMaskReg), .loadAllMask(loadAllMask),
    .readStatusReg(readStatusReg), .readTemporaryReg(readTemporaryReg),
    .loadIoDataBufferFromStatus(loadIoDataBufferFromStatus), .upperByte(upperByte)
  );

  localparam logic [14:0] NONE = 15'h0000;
  localparam logic [14:0] LBA  = 15'h4000;
  localparam logic [14:0] LBWC = 15'h2000;
  localparam logic [14:0] RCA  = 15'h1000;
  localparam logic [14:0] RCWC = 15'h0800;
  localparam logic [14:0] CMD  = 15'h0400;
  localparam logic [14:0] REQ  = 15'h0200;
  localparam logic [14:0] SMSK = 15'h0100;
  localparam logic [14:0] MODE = 15'h0080;
  localparam logic [14:0] CLRF = 15'h0040;
  localparam logic [14:0] MCLR = 15'h0020;
  localparam logic [14:0] CLRM = 15'h0010;
  localparam logic [14:0] AMSK = 15'h0008;
  localparam logic [14:0] STAT = 15'h0006;
  localparam logic [14:0] TEMP = 15'h0002 >> 1 << 1;

  typedef struct {
    logic       csN;
    logic       iorN;
    logic       iowN;
    logic       pc;
    logic [3:0] a;
    logic [14:0] expStr;
    logic [3:0]  expSel;
  } vec_t;

  vec_t vecs[$];
  logic ubQueue[$];
  int nVec = 0;
  int nMis = 0;
  logic expUb;
  logic expAccPrev;

  function automatic logic [14:0] packStrobes();
    return {loadBaseAddressReg, loadBaseWordCountReg, readCurrentAddressReg, readCurrentWordCountReg,
            loadCommandReg, loadRequestReg, loadSingleMask, loadModeReg, clearInternalFF,
            masterClear, clearMaskReg, loadAllMask, readStatusReg, loadIoDataBufferFromStatus,
            readTemporaryReg};
  endfunction

  function automatic vec_t mk(logic csN, logic iorN, logic iowN, logic pc, logic [3:0] a,
                              logic [14:0] s, logic [3:0] sel);
    vec_t v;
    v.csN = csN; v.iorN = iorN; v.iowN = iowN; v.pc = pc; v.a = a; v.expStr = s; v.expSel = sel;
    return v;
  endfunction

  task automatic checkComb(string name, logic [14:0] expS, logic [3:0] expC);
    nVec++;
    if (packStrobes() !== expS || channelSel !== expC) begin
      nMis++;
      $display("FAIL %s: strobes=%h sel=%b, required strobes=%h sel=%b",
               name, packStrobes(), channelSel, expS, expC);
    end
  endtask

  task automatic checkUb(string name, logic expV);
    nVec++;
    if (upperByte !== expV) begin
      nMis++;
      $display("FAIL %s: upperByte=%b, required %b", name, upperByte, expV);
    end
  endtask

  task automatic applyVec(int idx, vec_t v);
    logic acc;
    logic clr;
    @(negedge CLK);
    CS_N = v.csN; IOR_N = v.iorN; IOW_N = v.iowN; programCondition = v.pc; A = v.a;
    #2;
    checkComb($sformatf("vec%0d strobes", idx), v.expStr, v.expSel);
    acc = |(v.expStr & (LBA | LBWC | RCA | RCWC));
    clr = |(v.expStr & (CLRF | MCLR));
    if (clr) expUb = 1'b0;
    else if (expAccPrev && !acc) expUb = !expUb;
    expAccPrev = acc;
    ubQueue.push_back(expUb);
    @(posedge CLK);
    #1;
    checkUb($sformatf("vec%0d upperByte", idx), ubQueue.pop_front());
  endtask

  initial begin
    RESET_N = 1'b0; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; A = 4'h0; programCondition = 1'b0;
    expUb = 1'b0;
    expAccPrev = 1'b0;

    // Reset held with random bus activity.
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      CS_N = 1'($urandom); IOR_N = 1'($urandom); IOW_N = 1'($urandom);
      A = 4'($urandom); programCondition = 1'($urandom);
      #2;
      checkComb($sformatf("reset%0d strobes", i), NONE, 4'b0000);
      checkUb($sformatf("reset%0d upperByte", i), 1'b0);
    end
    @(negedge CLK);
    RESET_N = 1'b1; CS_N = 1'b1;

    vecs.push_back(mk(1, 1, 1, 1, 4'h0, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h8, CMD, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 0, 4'h8, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h4, LBA, 4'b0100));
    vecs.push_back(mk(0, 1, 0, 1, 4'h4, LBA, 4'b0100));
    vecs.push_back(mk(1, 1, 1, 1, 4'h4, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h4, LBA, 4'b0100));
    vecs.push_back(mk(1, 1, 1, 1, 4'h4, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h1, LBWC, 4'b0001));
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'hC, CLRF, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'h8, STAT, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'h9, NONE, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'hD, 15'h0001, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'hC, NONE, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'hE, NONE, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'hF, NONE, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'h2, RCA, 4'b0010));
    vecs.push_back(mk(0, 1, 1, 1, 4'h2, NONE, 4'b0000));
    vecs.push_back(mk(0, 0, 1, 1, 4'h7, RCWC, 4'b1000));
    vecs.push_back(mk(0, 0, 1, 1, 4'h5, RCWC, 4'b0100));
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, NONE, 4'b0000));
    vecs.push_back(mk(0, 0, 0, 1, 4'hB, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h9, REQ, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'hA, SMSK, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'hB, MODE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'hE, CLRM, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'hF, AMSK, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h3, LBWC, 4'b0010));
    vecs.push_back(mk(0, 1, 0, 1, 4'hD, MCLR, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 0, 4'h6, NONE, 4'b0000));
    vecs.push_back(mk(1, 1, 0, 1, 4'h6, NONE, 4'b0000));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 1, 4'h0, LBA, 4'b0001));
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h6, LBA, 4'b1000));
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, NONE, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h0, LBA, 4'b0001));
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, NONE, 4'b0000));

    foreach (vecs[i]) applyVec(i, vecs[i]);
    checkUb("pre-abort upperByte", 1'b1);

    // Reset asserted in the middle of a word count write.
    @(negedge CLK);
    CS_N = 1'b0; IOR_N = 1'b1; IOW_N = 1'b0; programCondition = 1'b1; A = 4'h7;
    #2;
    checkComb("abort active strobe", LBWC, 4'b1000);
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    checkComb("abort strobes dropped", NONE, 4'b0000);
    checkUb("abort upperByte cleared", 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1; CS_N = 1'b1; IOW_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      checkUb($sformatf("abort post-release%0d upperByte", i), 1'b0);
    end

    if (ubQueue.size() != 0) begin
      nMis++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", ubQueue.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/reference_model.md
Name: reference_model

Overview:
- Cycle-accurate decode model of the 8237-style DMA controller's CPU programming interface.
- Watches chip select, I/O read/write strobes, low address bits and the program-condition flag, and produces one strobe per internal register access.
- Tracks the byte-pointer (internal) flip-flop.
- Sits beside the DMA core inside the SVA checker; assertions compare core register updates against its strobes.

Parameters:
- NUM_CH, 4, number of DMA channels. Fixed at 4; the address map depends on it.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- CS_N  input  1  chip select, active low.
- IOR_N  input  1  I/O read strobe, active low.
- IOW_N  input  1  I/O write strobe, active low.
- A  input  4  register address (bus A3..A0).
- programCondition  input  1  high when the controller is in program (CPU) mode, i.e. idle and not bus master.
- loadBaseAddressReg  output  1  write to base+current address register.
- loadBaseWordCountReg  output  1  write to base+current word count register.
- readCurrentAddressReg  output  1  read of current address register.
- readCurrentWordCountReg  output  1  read of current word count register.
- channelSel  output  4  one-hot channel of the address/count access (A[2:1]).
- loadCommandReg  output  1  command register write.
- loadRequestReg  output  1  request register write.
- loadSingleMask  output  1  single mask bit write.
- loadModeReg  output  1  mode register write.
- clearInternalFF  output  1  clear byte-pointer flip-flop command.
- masterClear  output  1  master clear command.
- clearMaskReg  output  1  clear all mask bits command.
- loadAllMask  output  1  write all mask bits.
- readStatusReg  output  1  status register read.
- readTemporaryReg  output  1  temporary register read.
- loadIoDataBufferFromStatus  output  1  equal to readStatusReg.
- upperByte  output  1  byte-pointer flip-flop value; 1 selects the upper byte.

Behaviour:
- Qualifier: valid = !CS_N && programCondition && (IOR_N ^ IOW_N).
  - wr = valid && !IOW_N; rd = valid && !IOR_N.
  - IOR_N and IOW_N both low gives no strobe.
- All decode strobes are combinational from the current inputs (zero latency). Each is high exactly while its condition holds.
- Write map:
  - A=0,2,4,6: loadBaseAddressReg.
  - A=1,3,5,7: loadBaseWordCountReg.
  - 8: loadCommandReg.
  - 9: loadRequestReg.
  - A: loadSingleMask.
  - B: loadModeReg.
  - C: clearInternalFF.
  - D: masterClear.
  - E: clearMaskReg.
  - F: loadAllMask.
- Read map:
  - A=0,2,4,6: readCurrentAddressReg.
  - A=1,3,5,7: readCurrentWordCountReg.
  - 8: readStatusReg (and loadIoDataBufferFromStatus).
  - D: readTemporaryReg.
  - 9,A,B,C,E,F: no strobe (reserved).
- channelSel = one-hot(A[2:1]) when any address/count strobe is active, else 4'b0000.
- At most one strobe is high in any cycle; decode is mutually exclusive.
- Byte-pointer flip-flop (upperByte), registered:
  - Reset value 0.
  - Let acc = any of the four address/count strobes. accPrev = acc registered, reset 0.
  - Priority per rising edge:
    1. clearInternalFF or masterClear → 0.
    2. Else accPrev && !acc (end of a byte access) → toggle.
    3. Else hold.
  - A strobe held for many cycles toggles the flip-flop only once.
  - Back-to-back accesses separated by at least one idle cycle toggle once each.
- Asynchronous reset (RESET_N low):
  - upperByte and accPrev go to 0 immediately.
  - Combinational strobes are forced to 0 while RESET_N is low.
  - A reset mid-access aborts the pending toggle.
- programCondition low (DMA service) suppresses all strobes. upperByte holds its value.

Test Plan:
- Reset: RESET_N=0 for 2 cycles with random bus → all outputs 0, upperByte=0. Release with CS_N=1 → outputs stay 0.
- Command write: CS_N=0, programCondition=1, IOW_N=0, IOR_N=1, A=8 for 1 cycle → loadCommandReg=1 that cycle only, all other strobes 0. With programCondition=0 → no strobe.
- Address pair: write A=4 for 2 cycles, idle, write A=4 again →
  - loadBaseAddressReg=1, channelSel=0100.
  - upperByte 0→1 one cycle after the first access ends, 1→0 after the second.
  - Then write A=C → upperByte=0 next edge.
- Status read: IOR_N=0, A=8 → readStatusReg=1 and loadIoDataBufferFromStatus=1. A=9 read → no strobe.
- Illegal strobes: IOR_N=0 and IOW_N=0 with A=B → every strobe 0, upperByte unchanged.
- Reset mid-access: word count write A=7 active, RESET_N pulsed low asynchronously → strobes drop immediately, upperByte stays 0 after release.
